// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU execute/writeback stage: sizes, opcodes, flag bits, FSM states.
package alu_exec_stage_pkg;

  localparam int unsigned DataWidth   = 8;
  localparam int unsigned RegCount    = 32;
  localparam int unsigned AddrWidth   = 5;
  localparam int unsigned OPSEL_COUNT = 4;

  typedef logic [OPSEL_COUNT-1:0] opsel_t;

  localparam opsel_t OPSEL_NOP = 4'd0;
  localparam opsel_t OPSEL_ADD = 4'd1;
  localparam opsel_t OPSEL_ADC = 4'd2;
  localparam opsel_t OPSEL_SUB = 4'd3;
  localparam opsel_t OPSEL_SBC = 4'd4;
  localparam opsel_t OPSEL_AND = 4'd5;
  localparam opsel_t OPSEL_OR  = 4'd6;
  localparam opsel_t OPSEL_EOR = 4'd7;

  localparam int unsigned FLAGS_C = 0;
  localparam int unsigned FLAGS_Z = 1;
  localparam int unsigned FLAGS_N = 2;
  localparam int unsigned FLAGS_V = 3;
  localparam int unsigned FLAGS_S = 4;
  localparam int unsigned FLAGS_H = 5;
  localparam int unsigned FLAGS_T = 6;
  localparam int unsigned FLAGS_I = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_stage_reg_file.sv
// General-purpose register file: two operand read ports, one debug read port, one write port.
module alu_exec_stage_reg_file #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = mem_q[raddr_a_i];
  assign rdata_b_o  = mem_q[raddr_b_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage around the combinational ALU; owns the register file and SREG.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned REG_COUNT  = RegCount,
  parameter int unsigned ADDR_WIDTH = AddrWidth
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPSEL_COUNT-1:0] in_opsel,
  input  logic [ADDR_WIDTH-1:0]  in_rd_addr,
  input  logic [ADDR_WIDTH-1:0]  in_rr_addr,
  input  logic                   ld_en,
  input  logic [ADDR_WIDTH-1:0]  ld_addr,
  input  logic [DATA_WIDTH-1:0]  ld_data,
  output logic [OPSEL_COUNT-1:0] alu_opsel,
  output logic                   alu_enable,
  output logic [DATA_WIDTH-1:0]  alu_rd,
  output logic [DATA_WIDTH-1:0]  alu_rr,
  output logic [DATA_WIDTH-1:0]  alu_flags_in,
  input  logic [DATA_WIDTH-1:0]  alu_out,
  input  logic [DATA_WIDTH-1:0]  alu_flags_out,
  output logic [DATA_WIDTH-1:0]  sreg,
  input  logic [ADDR_WIDTH-1:0]  dbg_addr,
  output logic [DATA_WIDTH-1:0]  dbg_data,
  output logic                   done
);

  state_e                 state_q;
  opsel_t                 opsel_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic [DATA_WIDTH-1:0]  op_rd_q, op_rr_q, res_q, flg_q, sreg_q;
  logic                   enable_q, done_q;

  logic [DATA_WIDTH-1:0]  rf_rd_data, rf_rr_data, rf_wdata;
  logic [ADDR_WIDTH-1:0]  rf_waddr;
  logic                   wb_we, ld_we, rf_we;

  // Writeback has priority; direct loads only slip in while idle with no instruction offered.
  assign wb_we    = (state_q == StWb) && (opsel_q != OPSEL_NOP);
  assign ld_we    = (state_q == StIdle) && !in_valid && ld_en;
  assign rf_we    = wb_we || ld_we;
  assign rf_waddr = wb_we ? rd_addr_q : ld_addr;
  assign rf_wdata = wb_we ? res_q : ld_data;

  alu_exec_stage_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_reg_file (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (in_rd_addr),
    .rdata_a_o  (rf_rd_data),
    .raddr_b_i  (in_rr_addr),
    .rdata_b_o  (rf_rr_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      opsel_q   <= OPSEL_NOP;
      rd_addr_q <= '0;
      op_rd_q   <= '0;
      op_rr_q   <= '0;
      res_q     <= '0;
      flg_q     <= '0;
      sreg_q    <= '0;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            opsel_q   <= in_opsel;
            rd_addr_q <= in_rd_addr;
            op_rd_q   <= rf_rd_data;
            op_rr_q   <= rf_rr_data;
            enable_q  <= 1'b1;
            state_q   <= StExec;
          end
        end
        StExec: begin
          res_q    <= alu_out;
          flg_q    <= alu_flags_out;
          enable_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StWb;
        end
        StWb: begin
          // NOP still commits: the ALU passes flags_in through unchanged.
          sreg_q  <= flg_q;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          enable_q <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign in_ready     = rst_n && (state_q == StIdle);
  assign alu_enable   = enable_q;
  assign done         = done_q;
  assign alu_opsel    = opsel_q;
  assign alu_rd       = op_rd_q;
  assign alu_rr       = op_rr_q;
  assign alu_flags_in = sreg_q;
  assign sreg         = sreg_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage with a behavioural AVR-style ALU and architectural model.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opsel;
  logic [4:0] in_rd_addr, in_rr_addr;
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic [3:0] alu_opsel;
  logic       alu_enable;
  logic [7:0] alu_rd, alu_rr, alu_flags_in, alu_out, alu_flags_out, sreg;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       done;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_reg [32];
  logic [7:0] exp_sreg;
  logic       rdy_pre, rdy_x, rdy_w, rdy_i, dn_x, dn_w, dn_i;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opsel      (in_opsel),
    .in_rd_addr    (in_rd_addr),
    .in_rr_addr    (in_rr_addr),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .alu_opsel     (alu_opsel),
    .alu_enable    (alu_enable),
    .alu_rd        (alu_rd),
    .alu_rr        (alu_rr),
    .alu_flags_in  (alu_flags_in),
    .alu_out       (alu_out),
    .alu_flags_out (alu_flags_out),
    .sreg          (sreg),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .done          (done)
  );

  // AVR-like ALU: returns {flags_out, out}.
  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] f);
    logic [7:0] r;
    logic [7:0] fo;
    int cin, sum, ia, ib;
    fo = f;
    r = a;
    ia = int'(a);
    ib = int'(b);
    cin = ((op == OPSEL_ADC) || (op == OPSEL_SBC)) ? int'(f[FLAGS_C]) : 0;
    if (op == OPSEL_NOP) return {f, a};
    case (op)
      OPSEL_ADD, OPSEL_ADC: begin
        sum = ia + ib + cin;
        r = 8'(sum);
        fo[FLAGS_C] = sum > 255;
        fo[FLAGS_H] = ((ia % 16) + (ib % 16) + cin) > 15;
        fo[FLAGS_V] = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OPSEL_SUB, OPSEL_SBC: begin
        sum = ia - ib - cin;
        r = 8'(sum);
        fo[FLAGS_C] = ia < (ib + cin);
        fo[FLAGS_H] = (ia % 16) < ((ib % 16) + cin);
        fo[FLAGS_V] = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OPSEL_AND: begin r = a & b; fo[FLAGS_V] = 1'b0; end
      OPSEL_OR:  begin r = a | b; fo[FLAGS_V] = 1'b0; end
      default:   begin r = a ^ b; fo[FLAGS_V] = 1'b0; end
    endcase
    fo[FLAGS_N] = r[7];
    fo[FLAGS_Z] = (r == 8'h00) && ((op != OPSEL_SBC) || f[FLAGS_Z]);
    fo[FLAGS_S] = fo[FLAGS_N] ^ fo[FLAGS_V];
    return {fo, r};
  endfunction

  always_comb begin
    {alu_flags_out, alu_out} = 16'h0000;
    if (alu_enable) {alu_flags_out, alu_out} = alu_model(alu_opsel, alu_rd, alu_rr, alu_flags_in);
  end

  function automatic void model_apply(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rr);
    logic [15:0] res;
    res = alu_model(op, exp_reg[rd], exp_reg[rr], exp_sreg);
    if (op != OPSEL_NOP) exp_reg[rd] = res[7:0];
    exp_sreg = res[15:8];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) exp_reg[i] = 8'h00;
    exp_sreg = 8'h00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic load(input logic [4:0] addr, input logic [7:0] data);
    @(negedge clk);
    ld_en = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(posedge clk);
    #1 ld_en = 1'b0;
    exp_reg[addr] = data;
  endtask

  // Issues one instruction and records handshake observations; ends idle with dbg_addr=rd.
  task automatic do_op(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rr);
    @(negedge clk);
    rdy_pre = in_ready;
    in_valid = 1'b1;
    in_opsel = op;
    in_rd_addr = rd;
    in_rr_addr = rr;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_apply(op, rd, rr);
    @(negedge clk); rdy_x = in_ready; dn_x = done;
    @(negedge clk); rdy_w = in_ready; dn_w = done;
    @(negedge clk); rdy_i = in_ready; dn_i = done;
    dbg_addr = rd;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (alu_enable !== 1'b0) begin failures++; $display("FAIL reset_alu_enable got=%b exp=0", alu_enable); end
    checks++; if (sreg !== 8'h00) begin failures++; $display("FAIL reset_sreg got=%h exp=00", sreg); end
    dbg_addr = 5'd31;
    #1;
    checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL reset_r31 got=%h exp=00", dbg_data); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    do_reset();
    load(5'd1, 8'h7F);
    load(5'd2, 8'h01);
    do_op(OPSEL_ADD, 5'd1, 5'd2);
    checks++; if (dbg_data !== 8'h80) begin failures++; $display("FAIL add_r1 got=%h exp=80", dbg_data); end
    checks++; if (sreg !== 8'h2C) begin failures++; $display("FAIL add_sreg got=%h exp=2C", sreg); end
    checks++; if ({rdy_pre, rdy_x, rdy_w, rdy_i} !== 4'b1001) begin
      failures++; $display("FAIL add_ready_window got=%b exp=1001", {rdy_pre, rdy_x, rdy_w, rdy_i});
    end
    checks++; if ({dn_x, dn_w, dn_i} !== 3'b010) begin
      failures++; $display("FAIL add_done_pulse got=%b exp=010", {dn_x, dn_w, dn_i});
    end
  endtask

  task automatic test_sub_same();
    load(5'd3, 8'h10);
    do_op(OPSEL_SUB, 5'd3, 5'd3);
    checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL sub_same_r3 got=%h exp=00", dbg_data); end
    checks++; if (sreg !== 8'h02) begin failures++; $display("FAIL sub_same_sreg got=%h exp=02", sreg); end
  endtask

  task automatic test_carry_chain();
    load(5'd4, 8'hFF);
    load(5'd5, 8'h01);
    do_op(OPSEL_ADD, 5'd4, 5'd5);
    checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL carry_r4 got=%h exp=00", dbg_data); end
    checks++; if (sreg !== 8'h23) begin failures++; $display("FAIL carry_sreg got=%h exp=23", sreg); end
    load(5'd6, 8'h00);
    load(5'd7, 8'h00);
    do_op(OPSEL_ADC, 5'd6, 5'd7);
    checks++; if (dbg_data !== 8'h01) begin failures++; $display("FAIL adc_r6 got=%h exp=01", dbg_data); end
    checks++; if (sreg !== 8'h00) begin failures++; $display("FAIL adc_sreg got=%h exp=00", sreg); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] rdy;
    load(5'd1, 8'h7F);
    load(5'd2, 8'h01);
    @(negedge clk);
    in_valid = 1'b1;
    in_opsel = OPSEL_ADD;
    in_rd_addr = 5'd1;
    in_rr_addr = 5'd2;
    @(posedge clk);
    #1 in_opsel = OPSEL_AND;
    model_apply(OPSEL_ADD, 5'd1, 5'd2);
    @(negedge clk); rdy[0] = in_ready;
    @(negedge clk); rdy[1] = in_ready;
    @(negedge clk); rdy[2] = in_ready;
    dbg_addr = 5'd1;
    #1;
    checks++; if (rdy !== 3'b100) begin failures++; $display("FAIL b2b_accept_gap got=%b exp=100", rdy); end
    checks++; if (dbg_data !== 8'h80) begin failures++; $display("FAIL b2b_first_r1 got=%h exp=80", dbg_data); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_apply(OPSEL_AND, 5'd1, 5'd2);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL b2b_and_r1 got=%h exp=00", dbg_data); end
    checks++; if (sreg !== 8'h22) begin failures++; $display("FAIL b2b_and_sreg got=%h exp=22", sreg); end
    checks++; if (sreg !== exp_sreg) begin failures++; $display("FAIL b2b_model_sreg got=%h exp=%h", sreg, exp_sreg); end
  endtask

  task automatic test_nop_and_load_gating();
    logic [7:0] r1_before, sreg_before;
    r1_before = exp_reg[1];
    sreg_before = exp_sreg;
    do_op(OPSEL_NOP, 5'd1, 5'd2);
    checks++; if (dbg_data !== r1_before) begin failures++; $display("FAIL nop_r1 got=%h exp=%h", dbg_data, r1_before); end
    checks++; if (sreg !== sreg_before) begin failures++; $display("FAIL nop_sreg got=%h exp=%h", sreg, sreg_before); end
    checks++; if (dn_w !== 1'b1) begin failures++; $display("FAIL nop_done got=%b exp=1", dn_w); end
    // Loads attempted during EXEC and WB must be dropped.
    @(negedge clk);
    in_valid = 1'b1; in_opsel = OPSEL_ADD; in_rd_addr = 5'd3; in_rr_addr = 5'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_apply(OPSEL_ADD, 5'd3, 5'd4);
    ld_en = 1'b1; ld_addr = 5'd9; ld_data = 8'hA5;
    @(posedge clk);
    #1 ld_addr = 5'd10; ld_data = 8'h5A;
    @(posedge clk);
    #1 ld_en = 1'b0;
    // Instruction accept wins over a simultaneous load.
    @(negedge clk);
    in_valid = 1'b1; in_opsel = OPSEL_OR; in_rd_addr = 5'd12; in_rr_addr = 5'd3;
    ld_en = 1'b1; ld_addr = 5'd11; ld_data = 8'hC3;
    @(posedge clk);
    #1 in_valid = 1'b0; ld_en = 1'b0;
    model_apply(OPSEL_OR, 5'd12, 5'd3);
    repeat (3) @(negedge clk);
    dbg_addr = 5'd9; #1;
    checks++; if (dbg_data !== exp_reg[9]) begin failures++; $display("FAIL ld_exec_r9 got=%h exp=%h", dbg_data, exp_reg[9]); end
    dbg_addr = 5'd10; #1;
    checks++; if (dbg_data !== exp_reg[10]) begin failures++; $display("FAIL ld_wb_r10 got=%h exp=%h", dbg_data, exp_reg[10]); end
    dbg_addr = 5'd11; #1;
    checks++; if (dbg_data !== exp_reg[11]) begin failures++; $display("FAIL ld_accept_r11 got=%h exp=%h", dbg_data, exp_reg[11]); end
    dbg_addr = 5'd12; #1;
    checks++; if (dbg_data !== exp_reg[12]) begin failures++; $display("FAIL or_r12 got=%h exp=%h", dbg_data, exp_reg[12]); end
  endtask

  task automatic test_reset_mid_op();
    logic done_seen;
    load(5'd1, 8'h7F);
    load(5'd2, 8'h01);
    @(negedge clk);
    in_valid = 1'b1; in_opsel = OPSEL_ADD; in_rd_addr = 5'd1; in_rr_addr = 5'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 rst_n = 1'b0;
    dbg_addr = 5'd1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
    checks++; if (sreg !== 8'h00) begin failures++; $display("FAIL midrst_sreg got=%h exp=00", sreg); end
    checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL midrst_r1 got=%h exp=00", dbg_data); end
    done_seen = done;
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_release_ready got=%b exp=1", in_ready); end
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    #1;
    checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done_seen); end
    checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL midrst_r1_after got=%h exp=00", dbg_data); end
    checks++; if (sreg !== 8'h00) begin failures++; $display("FAIL midrst_sreg_after got=%h exp=00", sreg); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [4:0] rd, rr;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        load(5'($urandom_range(0, 7)), 8'($urandom));
      end else begin
        op = 4'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        rr = 5'($urandom_range(0, 7));
        do_op(op, rd, rr);
        checks++; if (dbg_data !== exp_reg[rd]) begin
          failures++; $display("FAIL rand_rd op=%0d rd=%0d got=%h exp=%h", op, rd, dbg_data, exp_reg[rd]);
        end
        checks++; if (sreg !== exp_sreg) begin
          failures++; $display("FAIL rand_sreg op=%0d got=%h exp=%h", op, sreg, exp_sreg);
        end
        checks++; if ({rdy_x, rdy_w, dn_w, dn_i} !== 4'b0010) begin
          failures++; $display("FAIL rand_handshake got=%b exp=0010", {rdy_x, rdy_w, dn_w, dn_i});
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      checks++; if (dbg_data !== exp_reg[i]) begin
        failures++; $display("FAIL sweep_r%0d got=%h exp=%h", i, dbg_data, exp_reg[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_opsel = OPSEL_NOP;
    in_rd_addr = '0;
    in_rr_addr = '0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    dbg_addr = '0;
    model_reset();
    test_reset();
    test_add();
    test_sub_same();
    test_carry_chain();
    test_back_to_back();
    test_nop_and_load_gating();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback stage wrapped around the existing combinational ALU.
- Accepts one decoded instruction per handshake and reads both operands from an internal 32x8 register file.
- Drives the ALU from registered operands, captures `out`/`flags_out`, writes the result back to the register file and updates SREG.
- Sits between the decoder (upstream) and the ALU; it owns the architectural register state.

Parameters:
- DATA_WIDTH, 8, width of registers, operands and SREG.
- REG_COUNT, 32, number of general-purpose registers.
- ADDR_WIDTH, 5, register address width (clog2 of REG_COUNT).

Ports:
- clk  in  1  stage clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoder presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_opsel  in  OPSEL_COUNT  ALU operation code.
- in_rd_addr  in  ADDR_WIDTH  destination/first operand register.
- in_rr_addr  in  ADDR_WIDTH  second operand register.
- ld_en  in  1  direct register load (bring-up/test).
- ld_addr  in  ADDR_WIDTH  load address.
- ld_data  in  DATA_WIDTH  load data.
- alu_opsel  out  OPSEL_COUNT  to ALU `opsel`.
- alu_enable  out  1  to ALU `enable`; high only in EXEC.
- alu_rd  out  DATA_WIDTH  to ALU `rd`.
- alu_rr  out  DATA_WIDTH  to ALU `rr`.
- alu_flags_in  out  DATA_WIDTH  to ALU `flags_in`; equals sreg.
- alu_out  in  DATA_WIDTH  from ALU `out`.
- alu_flags_out  in  DATA_WIDTH  from ALU `flags_out`.
- sreg  out  DATA_WIDTH  status register (bit order per FLAGS_* defines: C0 Z1 N2 V3 S4 H5 T6 I7).
- dbg_addr  in  ADDR_WIDTH  debug read address.
- dbg_data  out  DATA_WIDTH  combinational read of regfile[dbg_addr].
- done  out  1  one-cycle pulse when writeback commits.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; all registers and sreg = 0.
  - operand/result registers = 0; done=0; alu_enable=0.
  - Reset mid-operation aborts the instruction: no partial write, no SREG update.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid: latch opsel, rd_addr, rr_addr, regfile[rd_addr] and regfile[rr_addr] into operand registers; go to EXEC.
  - If in_rd_addr==in_rr_addr, both operands get the same value.
- EXEC:
  - in_ready=0; alu_enable=1; alu_* driven from operand registers.
  - At the edge: capture alu_out into res_q and alu_flags_out into flg_q; go to WB.
- WB:
  - in_ready=0.
  - At the edge: regfile[rd_addr_q] <= res_q unless opsel is OPSEL_NOP; sreg <= flg_q unconditionally (NOP passes flags through unchanged).
  - done=1 during WB; go to IDLE.
- Latency and throughput:
  - Accept edge N; result visible on dbg_data and sreg after edge N+2.
  - Throughput is 1 instruction per 3 cycles.
- Read-after-write: the next instruction is accepted only in IDLE, after WB has committed, so it always sees the new value. No forwarding is needed.
- ld_en:
  - Writes regfile[ld_addr] <= ld_data only when state==IDLE and in_valid==0.
  - Ignored in every other case; instruction accept wins.
- alu_opsel/alu_rd/alu_rr hold the last operand values outside EXEC. alu_enable qualifies them.
- An undefined opsel follows ALU default behaviour (out = x). The write is still performed; the decoder must not issue undefined opcodes.

Decomposition:
- defines.vh (shared): OPSEL_* codes and OPSEL_COUNT, FLAGS_* bit indices, and new STATE_IDLE/STATE_EXEC/STATE_WB encodings (2-bit).
- One sub-module, reg_file:
  - REG_COUNT x DATA_WIDTH, async active-low reset to 0.
  - Two combinational read ports plus the debug read port.
  - One synchronous write port, muxed between WB and ld by the stage.

Test Plan:
- ADD: ld r1=0x7F, r2=0x01, sreg=0; issue ADD rd=1 rr=2 -> after WB r1=0x80, sreg=0x2C (H,V,N), done pulses once, in_ready low for exactly 2 cycles.
- SUB same register: r3=0x10; SUB rd=3 rr=3 -> r3=0x00, sreg=0x02 (Z only).
- Carry chain: r4=0xFF, r5=0x01, ADD rd=4 rr=5 -> r4=0x00, sreg=0x23 (H,Z,C); then r6=0x00, r7=0x00, ADC rd=6 rr=7 -> r6=0x01, sreg=0x00.
- Back-pressure and RAW: hold in_valid with ADD r1,r2 then AND r1,r2 back-to-back -> second accepted exactly 3 cycles after first; AND reads the updated r1 (0x80 & 0x01 = 0x00, sreg Z=1, V=0, C kept).
- NOP and load gating:
  - NOP rd=1 -> r1 unchanged, sreg unchanged, done pulses.
  - ld_en asserted during EXEC -> target register unchanged.
- Reset mid-op: deassert rst_n during EXEC of ADD r1=0x7F+0x01 -> immediately in_ready=0 while reset held, sreg=0x00, r1=0x00, done never pulses; after release in_ready=1.
